// File: rtl/pattern_gen_serial.sv
// Serial pattern transmitter: PATTERN (MSB first) repeated count_i times, GAP_LEN filler bits between repetitions.
// Latency: first bit valid the cycle after start_i is accepted; done_o pulses the cycle after the last transfer.
// Backpressure: while valid_o && !ready_i, d_o, valid_o and all counters hold for any number of cycles.
module pattern_gen_serial #(
    parameter int unsigned        PAT_LEN  = 5,
    parameter logic [PAT_LEN-1:0] PATTERN  = 5'b00101,
    parameter int unsigned        GAP_LEN  = 3,
    parameter logic               FILL_BIT = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic [7:0] count_i,
    input  logic       ready_i,
    output logic       d_o,
    output logic       valid_o,
    output logic       busy_o,
    output logic       done_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    // Pattern widened to 16 bits so the 4-bit bit counter indexes it exactly.
    localparam logic [15:0] PAT16    = 16'(PATTERN);
    localparam logic [3:0]  LAST_BIT = 4'(PAT_LEN - 1);
    localparam logic [3:0]  GAP_LAST = 4'(GAP_LEN - 1);

    state_t     state;
    logic [3:0] bit_cnt;
    logic [3:0] gap_cnt;
    logic [7:0] rep_cnt;
    logic       xfer;

    assign xfer = valid_o && ready_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            gap_cnt <= '0;
            rep_cnt <= '0;
            d_o     <= 1'b0;
            valid_o <= 1'b0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    valid_o <= 1'b0;
                    busy_o  <= 1'b0;
                    d_o     <= 1'b0;
                    if (start_i) begin
                        if (count_i != 8'd0) begin
                            rep_cnt <= count_i;
                            bit_cnt <= LAST_BIT;
                            state   <= S_SEND;
                            valid_o <= 1'b1;
                            busy_o  <= 1'b1;
                            d_o     <= PAT16[LAST_BIT];
                        end else begin
                            done_o <= 1'b1;
                        end
                    end
                end
                S_SEND: begin
                    if (xfer) begin
                        if (bit_cnt != 4'd0) begin
                            bit_cnt <= bit_cnt - 4'd1;
                            d_o     <= PAT16[bit_cnt - 4'd1];
                        end else if (rep_cnt > 8'd1) begin
                            rep_cnt <= rep_cnt - 8'd1;
                            if (GAP_LEN > 0) begin
                                state   <= S_GAP;
                                gap_cnt <= GAP_LAST;
                                d_o     <= FILL_BIT;
                            end else begin
                                bit_cnt <= LAST_BIT;
                                d_o     <= PAT16[LAST_BIT];
                            end
                        end else begin
                            state   <= S_IDLE;
                            rep_cnt <= '0;
                            valid_o <= 1'b0;
                            busy_o  <= 1'b0;
                            d_o     <= 1'b0;
                            done_o  <= 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    if (xfer) begin
                        if (gap_cnt == 4'd0) begin
                            state   <= S_SEND;
                            bit_cnt <= LAST_BIT;
                            d_o     <= PAT16[LAST_BIT];
                        end else begin
                            gap_cnt <= gap_cnt - 4'd1;
                        end
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    bit_cnt <= '0;
                    gap_cnt <= '0;
                    rep_cnt <= '0;
                    d_o     <= 1'b0;
                    valid_o <= 1'b0;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_gen_serial.sv
// Bench for pattern_gen_serial: stream-level model (queue of expected bits) checked every cycle,
// plus literal expectations for bit sequences, transfer counts, detector hits and latency.
module tb_pattern_gen_serial;

    localparam int          PAT_LEN  = 5;
    localparam logic [4:0]  PATTERN  = 5'b00101;
    localparam int          GAP_LEN  = 3;
    localparam logic        FILL_BIT = 1'b1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start_i = 1'b0;
    logic [7:0] count_i = 8'd0;
    logic       ready_i = 1'b1;
    logic       d_o, valid_o, busy_o, done_o;

    int checks = 0;
    int errors = 0;

    pattern_gen_serial #(
        .PAT_LEN (PAT_LEN),
        .PATTERN (PATTERN),
        .GAP_LEN (GAP_LEN),
        .FILL_BIT(FILL_BIT)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start_i(start_i),
        .count_i(count_i),
        .ready_i(ready_i),
        .d_o    (d_o),
        .valid_o(valid_o),
        .busy_o (busy_o),
        .done_o (done_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Model: the whole remaining bit stream of the current run sits in a queue.
    bit   q[$];
    logic m_done = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            m_done = 1'b0;
        end else if (q.size() != 0) begin
            m_done = 1'b0;
            if (ready_i) begin
                void'(q.pop_front());
                if (q.size() == 0) m_done = 1'b1;
            end
        end else begin
            m_done = 1'b0;
            if (start_i) begin
                if (count_i == 8'd0) begin
                    m_done = 1'b1;
                end else begin
                    for (int r = 0; r < int'(count_i); r++) begin
                        for (int b = PAT_LEN - 1; b >= 0; b--) q.push_back(PATTERN[b]);
                        if (r < int'(count_i) - 1)
                            for (int g = 0; g < GAP_LEN; g++) q.push_back(FILL_BIT);
                    end
                end
            end
        end
    end

    // Stream monitor and a sliding-window pattern detector over transferred bits.
    int          cyc = 0;
    int          xfer_cnt = 0;
    int          done_cnt = 0;
    int          det_cnt = 0;
    logic [63:0] log_bits = '0;
    logic [4:0]  det_win = '0;

    always @(posedge clk) begin
        logic [4:0] w;
        cyc++;
        if (done_o) done_cnt++;
        if (valid_o && ready_i) begin
            xfer_cnt++;
            log_bits = {log_bits[62:0], d_o};
            w = {det_win[3:0], d_o};
            det_win = w;
            if (xfer_cnt >= PAT_LEN && w == PATTERN) det_cnt++;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_valid", 32'(valid_o), 32'd0);
            chk("rst_busy",  32'(busy_o),  32'd0);
            chk("rst_done",  32'(done_o),  32'd0);
            chk("rst_d",     32'(d_o),     32'd0);
        end else begin
            chk("model_valid", 32'(valid_o), 32'(q.size() != 0));
            chk("model_busy",  32'(busy_o),  32'(q.size() != 0));
            chk("model_done",  32'(done_o),  32'(m_done));
            if (q.size() != 0) chk("model_d", 32'(d_o), 32'(q[0]));
        end
    end

    int start_cyc;

    task automatic start_run(input logic [7:0] n);
        @(negedge clk);
        xfer_cnt = 0;
        done_cnt = 0;
        det_cnt  = 0;
        log_bits = '0;
        det_win  = '0;
        start_i  = 1'b1;
        count_i  = n;
        @(negedge clk);
        start_i   = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_done(input int budget, output int at);
        int i;
        at = -1;
        i  = 0;
        while (at < 0 && i < budget) begin
            if (done_o) at = cyc;
            else @(negedge clk);
            i++;
        end
        if (at < 0) begin
            errors++;
            checks++;
            $display("FAIL done_timeout: no done_o within %0d cycles", budget);
        end
    endtask

    task automatic wait_xfers(input int n, input int budget);
        int i;
        i = 0;
        while (xfer_cnt < n && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk("xfer_reached", 32'(xfer_cnt), 32'(n));
    endtask

    initial begin
        int          at;
        logic [20:0] exp21;
        exp21 = 21'b001011110010111100101;

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // 1: single repetition
        start_run(8'd1);
        wait_done(40, at);
        chk("t1_bits",    32'(log_bits[4:0]), 32'(5'b00101));
        chk("t1_xfers",   32'(xfer_cnt), 32'd5);
        chk("t1_det",     32'(det_cnt),  32'd1);
        chk("t1_latency", 32'(at - start_cyc), 32'd5);

        // 2: three repetitions with gaps
        start_run(8'd3);
        wait_done(80, at);
        chk("t2_bits",  32'(log_bits[20:0]), 32'(exp21));
        chk("t2_xfers", 32'(xfer_cnt), 32'd21);
        chk("t2_det",   32'(det_cnt),  32'd3);
        chk("t2_latency", 32'(at - start_cyc), 32'd21);

        // 3: stall on the third bit
        start_run(8'd2);
        wait_xfers(2, 20);
        ready_i = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("t3_hold_d",     32'(d_o),     32'd1);
            chk("t3_hold_valid", 32'(valid_o), 32'd1);
        end
        chk("t3_hold_xfers", 32'(xfer_cnt), 32'd2);
        ready_i = 1'b1;
        wait_done(80, at);
        chk("t3_xfers", 32'(xfer_cnt), 32'd13);
        chk("t3_det",   32'(det_cnt),  32'd2);

        // 4: zero count
        start_run(8'd0);
        chk("t4_done",  32'(done_o),  32'd1);
        chk("t4_valid", 32'(valid_o), 32'd0);
        chk("t4_busy",  32'(busy_o),  32'd0);
        @(negedge clk);
        chk("t4_done_pulse", 32'(done_o), 32'd0);
        chk("t4_xfers", 32'(xfer_cnt), 32'd0);

        // 5: asynchronous reset during the second repetition
        start_run(8'd2);
        wait_xfers(10, 40);
        #2 rst = 1'b0;
        #1;
        chk("t5_rst_valid", 32'(valid_o), 32'd0);
        chk("t5_rst_busy",  32'(busy_o),  32'd0);
        chk("t5_rst_d",     32'(d_o),     32'd0);
        chk("t5_rst_done",  32'(done_o),  32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("t5_no_done", 32'(done_cnt), 32'd0);
        start_run(8'd1);
        wait_done(40, at);
        chk("t5_clean_bits",  32'(log_bits[4:0]), 32'(5'b00101));
        chk("t5_clean_xfers", 32'(xfer_cnt), 32'd5);

        // 6: start while busy is ignored
        start_run(8'd2);
        repeat (3) @(negedge clk);
        start_i = 1'b1;
        count_i = 8'd9;
        @(negedge clk);
        start_i = 1'b0;
        wait_done(80, at);
        chk("t6_xfers", 32'(xfer_cnt), 32'd13);
        repeat (3) @(negedge clk);
        chk("t6_done_cnt", 32'(done_cnt), 32'd1);
        chk("t6_idle_valid", 32'(valid_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
